// File: rtl/uart_frame_rx.sv
// Pops bytes from the UART RX FIFO, parses SOF/LEN/payload/CHK frames and
// streams the payload out only once the checksum has been verified.
module uart_frame_rx #(
  parameter int         MaxPayload    = 16,
  parameter logic [7:0] SofByte       = 8'h7E,
  parameter int         TimeoutCycles = 8680
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_rx_rdy,
  input  logic [7:0]                       i_rx_data,
  output logic                             o_rx_req,
  output logic [7:0]                       o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_last,
  output logic [$clog2(MaxPayload+1)-1:0]  o_len,
  output logic                             o_err_len,
  output logic                             o_err_chk,
  output logic                             o_err_tmo,
  output logic                             o_busy
);

  localparam int              LW      = $clog2(MaxPayload + 1);
  localparam int              IW      = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;
  localparam int              TW      = $clog2(TimeoutCycles + 1);
  localparam logic [7:0]      MaxLen  = 8'(MaxPayload);
  localparam logic [TW-1:0]   TmoLast = TW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  state_t          state;
  logic            rd_pending;
  logic [LW-1:0]   len;
  logic [LW-1:0]   idx;
  logic [7:0]      acc;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      pbuf [0:(1<<IW)-1];

  logic            cap;
  logic            in_frame;
  logic            tmo_hit;
  logic            buf_we;
  logic            req_ok;
  logic [7:0]      sum;

  always_comb begin
    // Byte is on i_rx_data in the cycle after the request pulse has dropped.
    cap      = rd_pending && !o_rx_req;
    in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    tmo_hit  = in_frame && !cap && (tmo_cnt == TmoLast);
    req_ok   = i_rx_rdy && !rd_pending && (state != S_OUT);
    sum      = acc + i_rx_data;
    buf_we   = cap && (state == S_PAYLOAD);
    o_data   = o_valid ? pbuf[idx[IW-1:0]] : '0;
    o_last   = o_valid && (idx == len - LW'(1));
  end

  always_ff @(posedge i_clk) begin
    if (buf_we) pbuf[idx[IW-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_HUNT;
      rd_pending <= 1'b0;
      o_rx_req   <= 1'b0;
      len        <= '0;
      idx        <= '0;
      acc        <= '0;
      tmo_cnt    <= '0;
      o_valid    <= 1'b0;
      o_len      <= '0;
      o_err_len  <= 1'b0;
      o_err_chk  <= 1'b0;
      o_err_tmo  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_err_len <= 1'b0;
      o_err_chk <= 1'b0;
      o_err_tmo <= 1'b0;
      o_rx_req  <= req_ok;
      if (req_ok)   rd_pending <= 1'b1;
      else if (cap) rd_pending <= 1'b0;
      tmo_cnt <= (in_frame && !cap) ? tmo_cnt + TW'(1) : '0;

      case (state)
        S_HUNT: begin
          if (cap && i_rx_data == SofByte) begin
            state  <= S_LEN;
            o_busy <= 1'b1;
          end
        end
        S_LEN: begin
          if (cap) begin
            if (i_rx_data == '0 || i_rx_data > MaxLen) begin
              o_err_len <= 1'b1;
              state     <= S_HUNT;
              o_busy    <= 1'b0;
            end else begin
              len   <= LW'(i_rx_data);
              acc   <= i_rx_data;
              idx   <= '0;
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (cap) begin
            acc <= sum;
            idx <= idx + LW'(1);
            if (idx + LW'(1) == len) state <= S_CHK;
          end
        end
        S_CHK: begin
          if (cap) begin
            if (sum == '0) begin
              state   <= S_OUT;
              idx     <= '0;
              o_valid <= 1'b1;
              o_len   <= len;
            end else begin
              o_err_chk <= 1'b1;
              state     <= S_HUNT;
              o_busy    <= 1'b0;
            end
          end
        end
        S_OUT: begin
          if (i_ready) begin
            if (o_last) begin
              state   <= S_HUNT;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_len   <= '0;
            end else begin
              idx <= idx + LW'(1);
            end
          end
        end
        default: state <= S_HUNT;
      endcase

      // tmo_hit implies no capture, so the case above left these untouched.
      if (tmo_hit) begin
        o_err_tmo <= 1'b1;
        state     <= S_HUNT;
        o_busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: a queue-based RX FIFO model feeds framed byte
// streams; expected payload beats and error counts come from the frame builder.
module tb_uart_frame_rx;

  localparam int MaxPayload = 16;
  localparam int Tmo        = 100;
  localparam int LW         = $clog2(MaxPayload + 1);

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_rx_rdy = 1'b0;
  logic [7:0]    i_rx_data = '0;
  logic          i_ready = 1'b0;
  logic          o_rx_req;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          o_last;
  logic [LW-1:0] o_len;
  logic          o_err_len;
  logic          o_err_chk;
  logic          o_err_tmo;
  logic          o_busy;

  uart_frame_rx #(
    .MaxPayload    (MaxPayload),
    .SofByte       (8'h7E),
    .TimeoutCycles (Tmo)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rx_rdy  (i_rx_rdy),
    .i_rx_data (i_rx_data),
    .o_rx_req  (o_rx_req),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_last    (o_last),
    .o_len     (o_len),
    .o_err_len (o_err_len),
    .o_err_chk (o_err_chk),
    .o_err_tmo (o_err_tmo),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]    d;
    logic          l;
    logic [LW-1:0] n;
  } beat_t;

  logic [7:0] fifo [$];
  logic [7:0] pl [$];
  beat_t      got [$];
  beat_t      exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cap_cyc = 0;
  int n_len = 0, n_chk = 0, n_tmo = 0;
  int e_len = 0, e_chk = 0, e_tmo = 0;
  bit req_seen = 0;
  bit rdy_rand = 0;
  bit ready_lvl = 1;
  bit prev_valid = 0, prev_ready = 0, prev_last = 0, prev_err = 0;
  logic [7:0]    prev_data = '0;
  logic [LW-1:0] prev_len = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: FIFO model, ready driver and output monitor.
  task automatic tick();
    int err_n;
    @(posedge i_clk);
    #1;
    cyc++;
    if (req_seen) begin
      check("pop_nonempty", 32'(fifo.size() != 0), 32'(1));
      if (fifo.size() != 0) begin
        i_rx_data = fifo.pop_front();
        cap_cyc   = cyc + 1;
      end
    end else begin
      i_rx_data = 8'($urandom);
    end
    i_rx_rdy = (fifo.size() != 0);
    req_seen = o_rx_req;
    i_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : ready_lvl;

    if (prev_valid && !prev_ready) begin
      check("hold_valid", 32'(o_valid), 32'(1));
      check("hold_data",  32'(o_data),  32'(prev_data));
      check("hold_last",  32'(o_last),  32'(prev_last));
      check("hold_len",   32'(o_len),   32'(prev_len));
    end
    err_n = int'(o_err_len) + int'(o_err_chk) + int'(o_err_tmo);
    check("err_excl", 32'((err_n > 1) || (err_n != 0 && (o_valid || prev_err))), 32'(0));
    check("req_in_out", 32'(o_rx_req && o_valid), 32'(0));
    n_len += int'(o_err_len);
    n_chk += int'(o_err_chk);
    n_tmo += int'(o_err_tmo);
    if (o_valid && i_ready) got.push_back('{d: o_data, l: o_last, n: o_len});
    prev_valid = o_valid;
    prev_ready = i_ready;
    prev_data  = o_data;
    prev_last  = o_last;
    prev_len   = o_len;
    prev_err   = (err_n != 0);
  endtask

  // Frame from pl; delta != 0 corrupts the checksum.
  task automatic add_frame(input logic [7:0] delta);
    int s = pl.size();
    int sum = s;
    logic [7:0] chk;
    foreach (pl[i]) sum += int'(pl[i]);
    chk = 8'((256 - (sum % 256)) % 256) + delta;
    fifo.push_back(8'h7E);
    fifo.push_back(8'(s));
    foreach (pl[i]) fifo.push_back(pl[i]);
    fifo.push_back(chk);
    if (delta == 8'h00) begin
      for (int i = 0; i < s; i++)
        exp_q.push_back('{d: pl[i], l: (i == s - 1), n: LW'(s)});
    end else begin
      e_chk++;
    end
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic add_bad_len(input logic [7:0] len);
    fifo.push_back(8'h7E);
    fifo.push_back(len);
    e_len++;
  endtask

  task automatic add_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom); while (b == 8'h7E);
      fifo.push_back(b);
    end
  endtask

  task automatic drain(input string tag);
    int quiet = 0;
    int budget = 0;
    while (quiet < 6 && budget < 20000) begin
      tick();
      budget++;
      if (fifo.size() == 0 && !req_seen && !o_busy && !o_valid) quiet++;
      else quiet = 0;
    end
    check({tag, "_drain"}, 32'(quiet >= 6), 32'(1));
  endtask

  task automatic compare(input string tag);
    check({tag, "_beats"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(got[i].d), 32'(exp_q[i].d));
      check($sformatf("%s_last%0d", tag, i), 32'(got[i].l), 32'(exp_q[i].l));
      check($sformatf("%s_len%0d",  tag, i), 32'(got[i].n), 32'(exp_q[i].n));
    end
    check({tag, "_err_len"}, 32'(n_len), 32'(e_len));
    check({tag, "_err_chk"}, 32'(n_chk), 32'(e_chk));
    check({tag, "_err_tmo"}, 32'(n_tmo), 32'(e_tmo));
    got.delete();
    exp_q.delete();
    n_len = 0; n_chk = 0; n_tmo = 0;
    e_len = 0; e_chk = 0; e_tmo = 0;
  endtask

  initial begin
    int k;
    int kind;

    // Reset state
    repeat (3) tick();
    check("rst_req",   32'(o_rx_req), 32'(0));
    check("rst_valid", 32'(o_valid),  32'(0));
    check("rst_data",  32'(o_data),   32'(0));
    check("rst_last",  32'(o_last),   32'(0));
    check("rst_len",   32'(o_len),    32'(0));
    check("rst_errs",  32'({o_err_len, o_err_chk, o_err_tmo}), 32'(0));
    check("rst_busy",  32'(o_busy),   32'(0));
    i_rst = 1'b0;
    tick();

    // Basic good frame: 7E 03 11 22 33 97
    pl = '{8'h11, 8'h22, 8'h33};
    add_frame(8'h00);
    drain("good3");
    compare("good3");

    // Checksum off by one (96), then 7E 01 55 AA
    pl = '{8'h11, 8'h22, 8'h33};
    add_frame(8'hFF);
    pl = '{8'h55};
    add_frame(8'h00);
    drain("badchk");
    compare("badchk");

    // Junk, LEN 0, LEN 17, then a maximum-length frame
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    add_bad_len(8'h00);
    add_bad_len(8'h11);
    rand_payload(MaxPayload);
    add_frame(8'h00);
    drain("lenbound");
    compare("lenbound");

    // Sink stall with bytes waiting in the FIFO
    ready_lvl = 1'b0;
    rand_payload(4);
    add_frame(8'h00);
    rand_payload(2);
    add_frame(8'h00);
    k = 0;
    while (!o_valid && k < 500) begin tick(); k++; end
    check("stall_reach", 32'(o_valid), 32'(1));
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_valid", 32'(o_valid),  32'(1));
      check("stall_data",  32'(o_data),   32'(exp_q[0].d));
      check("stall_last",  32'(o_last),   32'(0));
      check("stall_req",   32'(o_rx_req), 32'(0));
    end
    ready_lvl = 1'b1;
    drain("stall");
    compare("stall");

    // Inter-byte timeout after 7E 02 AA
    fifo.push_back(8'h7E);
    fifo.push_back(8'h02);
    fifo.push_back(8'hAA);
    k = 0;
    while (n_tmo == 0 && k < 1000) begin tick(); k++; end
    check("tmo_seen", 32'(n_tmo), 32'(1));
    check("tmo_latency", 32'(cyc - cap_cyc), 32'(Tmo));
    check("tmo_busy", 32'(o_busy), 32'(0));
    e_tmo = 1;
    rand_payload(5);
    add_frame(8'h00);
    drain("tmo");
    compare("tmo");

    // Reset in the middle of a payload
    fifo.push_back(8'h7E);
    fifo.push_back(8'h05);
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    k = 0;
    while (fifo.size() != 0 && k < 200) begin tick(); k++; end
    repeat (4) tick();
    check("mid_busy", 32'(o_busy), 32'(1));
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("mid_rst_outs", 32'({o_rx_req, o_data, o_valid, o_last, o_len,
                               o_err_len, o_err_chk, o_err_tmo}), 32'(0));
    check("mid_rst_busy", 32'(o_busy), 32'(0));
    rand_payload(7);
    add_frame(8'h00);
    drain("midrst");
    compare("midrst");

    // Random mix of junk, good, corrupted and bad-length frames
    rdy_rand = 1'b1;
    for (int f = 0; f < 20; f++) begin
      add_junk($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        rand_payload($urandom_range(1, MaxPayload));
        add_frame(8'h00);
      end else if (kind < 9) begin
        rand_payload($urandom_range(1, MaxPayload));
        add_frame(8'($urandom_range(1, 255)));
      end else begin
        add_bad_len(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MaxPayload + 1, 255)));
      end
    end
    drain("rand");
    rdy_rand = 1'b0;
    compare("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
